exe_stage_multicycle: RTL and testbench

//  Execute stage, directly downstream of the ID/EX pipeline register. Consumes Val1/Val2/Reg2/PC/EXE_CMD/Br_type.

---
 rtl/exe_stage_multicycle.sv | 184 ++++++++++++++++++
 tb/tb_exe_stage_multicycle.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/exe_stage_multicycle.sv
// Execute stage: single-cycle ALU, branch resolution, and an iterative MUL/DIV unit that stalls upstream.
// Define EXE_DIV_EN to build the restoring divider; without it opcode 1101 behaves as an unknown op.
module exe_stage_multicycle #(
  parameter int WIDTH    = 32,
  parameter int BR_SHIFT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [3:0]       EXE_CMD,
  input  logic [WIDTH-1:0] Val1,
  input  logic [WIDTH-1:0] Val2,
  input  logic [WIDTH-1:0] Reg2,
  input  logic [WIDTH-1:0] PC_in,
  input  logic [1:0]       Br_type,
  output logic [WIDTH-1:0] ALU_result,
  output logic [WIDTH-1:0] Br_addr,
  output logic             Br_taken,
  output logic             stall,
  output logic             md_done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_NOR = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRA = 4'b1001;
  localparam logic [3:0] OP_SRL = 4'b1010;
  localparam logic [3:0] OP_MUL = 4'b1100;
`ifdef EXE_DIV_EN
  localparam logic [3:0] OP_DIV = 4'b1101;
`endif

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc, op_a, op_b;
  logic [WIDTH-1:0] acc_nxt, a_nxt, b_nxt;
  logic [WIDTH-1:0] alu_out, md_result;
  logic [4:0]       shamt;
  logic             is_md, start;
`ifdef EXE_DIV_EN
  logic [WIDTH-1:0] rem, rem_nxt;
  logic             md_is_div;
`endif

  assign shamt = Val2[4:0];
`ifdef EXE_DIV_EN
  assign is_md = (EXE_CMD == OP_MUL) || (EXE_CMD == OP_DIV);
  assign md_result = md_is_div ? op_a : acc;
`else
  assign is_md = (EXE_CMD == OP_MUL);
  assign md_result = acc;
`endif
  assign start = is_md && !flush;

  always_comb begin
    alu_out = '0;
    case (EXE_CMD)
      OP_ADD:  alu_out = Val1 + Val2;
      OP_SUB:  alu_out = Val1 - Val2;
      OP_AND:  alu_out = Val1 & Val2;
      OP_OR:   alu_out = Val1 | Val2;
      OP_NOR:  alu_out = ~(Val1 | Val2);
      OP_XOR:  alu_out = Val1 ^ Val2;
      OP_SLL:  alu_out = Val1 << shamt;
      OP_SRA:  alu_out = $unsigned($signed(Val1) >>> shamt);
      OP_SRL:  alu_out = Val1 >> shamt;
      default: alu_out = '0;
    endcase
  end

  assign Br_addr = PC_in + (Val2 << BR_SHIFT);

  always_comb begin
    Br_taken = 1'b0;
    case (Br_type)
      2'b01:   Br_taken = (Val1 == '0);
      2'b10:   Br_taken = (Val1 != Reg2);
      2'b11:   Br_taken = 1'b1;
      default: Br_taken = 1'b0;
    endcase
    if (flush) Br_taken = 1'b0;
  end

  // One MUL/DIV iteration. MUL consumes the multiplier LSB-first while the multiplicand
  // shifts left; DIV shifts the dividend MSB into the remainder and the quotient bit in.
  always_comb begin
    acc_nxt = acc + (op_b[0] ? op_a : '0);
    a_nxt   = op_a << 1;
    b_nxt   = op_b >> 1;
`ifdef EXE_DIV_EN
    rem_nxt = {rem[WIDTH-2:0], op_a[WIDTH-1]};
    if (md_is_div) begin
      acc_nxt = acc;
      b_nxt   = op_b;
      if ({rem, op_a[WIDTH-1]} >= {1'b0, op_b}) begin
        rem_nxt = WIDTH'({rem, op_a[WIDTH-1]} - {1'b0, op_b});
        a_nxt   = {op_a[WIDTH-2:0], 1'b1};
      end else begin
        a_nxt   = {op_a[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (is_md) state_nxt = BUSY;
        BUSY:    if (cnt == LAST_ITER) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Operands are captured on entry to BUSY so upstream changes while busy have no effect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      acc  <= '0;
      op_a <= '0;
      op_b <= '0;
`ifdef EXE_DIV_EN
      rem       <= '0;
      md_is_div <= 1'b0;
`endif
    end else if (state == IDLE && start) begin
      cnt  <= '0;
      acc  <= '0;
      op_a <= Val1;
      op_b <= Val2;
`ifdef EXE_DIV_EN
      rem       <= '0;
      md_is_div <= (EXE_CMD == OP_DIV);
`endif
    end else if (state == BUSY) begin
      cnt  <= cnt + 1'b1;
      acc  <= acc_nxt;
      op_a <= a_nxt;
      op_b <= b_nxt;
`ifdef EXE_DIV_EN
      rem  <= rem_nxt;
`endif
    end
  end

  // Reset overrides everything so a MUL still sitting on the inputs cannot re-assert stall.
  always_comb begin
    stall      = 1'b0;
    md_done    = 1'b0;
    ALU_result = alu_out;
    case (state)
      IDLE:    stall = start;
      BUSY:    stall = !flush;
      DONE: begin
        md_done    = !flush;
        ALU_result = md_result;
      end
      default: stall = 1'b0;
    endcase
    if (rst) begin
      stall   = 1'b0;
      md_done = 1'b0;
    end
  end

endmodule

// File: tb/tb_exe_stage_multicycle.sv
// Directed bench for exe_stage_multicycle: vector table for single-cycle ops and branches,
// hand-written sequences for MUL/DIV latency, flush and reset corner cases.
module tb_exe_stage_multicycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [3:0]  exe_cmd;
  logic [31:0] val1, val2, reg2, pc_in;
  logic [1:0]  br_type;
  logic [31:0] alu_result, br_addr;
  logic        br_taken, stall, md_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] v1, v2, r2, pc;
    logic [1:0]  br;
    logic        fl;
    logic [31:0] e_res, e_addr;
    logic        e_taken;
  } vec_t;

  vec_t vecs[16];

  exe_stage_multicycle #(.WIDTH(32), .BR_SHIFT(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .EXE_CMD(exe_cmd),
    .Val1(val1), .Val2(val2), .Reg2(reg2), .PC_in(pc_in), .Br_type(br_type),
    .ALU_result(alu_result), .Br_addr(br_addr), .Br_taken(br_taken),
    .stall(stall), .md_done(md_done)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [3:0] cmd, input logic [31:0] v1, v2, r2, pc,
                               input logic [1:0] br, input logic fl);
    exe_cmd = cmd; val1 = v1; val2 = v2; reg2 = r2; pc_in = pc; br_type = br; flush = fl;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Presents a MUL/DIV, counts stall cycles until md_done, and leaves the bench in the cycle after DONE.
  task automatic runMd(input logic [3:0] cmd, input logic [31:0] a, b, expected, input string name);
    int stalls = 0;
    bit seen = 0;
    applyStimulus(cmd, a, b, 32'h0, 32'h0, 2'b00, 1'b0);
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (md_done) seen = 1;
      else begin
        if (stall) stalls++;
        nextCycle();
      end
    end
    checkOutput({name, "_done"}, {31'b0, seen}, 32'd1);
    checkOutput({name, "_stalls"}, 32'(stalls), 32'd33);
    checkOutput({name, "_res"}, alu_result, expected);
    checkOutput({name, "_stall_in_done"}, {31'b0, stall}, 32'd0);
    nextCycle();
  endtask

  initial begin
    bit pulsed, stalled;
    vecs[0]  = '{4'b0000, 32'h7,        32'hFFFFFFFF, 32'h0, 32'h0,   2'b00, 1'b0, 32'h6,        32'hFFFFFFFC, 1'b0};
    vecs[1]  = '{4'b1001, 32'h80000000, 32'h4,        32'h0, 32'h0,   2'b00, 1'b0, 32'hF8000000, 32'h10,       1'b0};
    vecs[2]  = '{4'b0010, 32'h5,        32'h7,        32'h0, 32'h0,   2'b00, 1'b0, 32'hFFFFFFFE, 32'h1C,       1'b0};
    vecs[3]  = '{4'b0100, 32'hFF00FF00, 32'h0000FFFF, 32'h0, 32'h0,   2'b00, 1'b0, 32'h0000FF00, 32'h3FFFC,    1'b0};
    vecs[4]  = '{4'b0101, 32'h000000F0, 32'h00000F00, 32'h0, 32'h0,   2'b00, 1'b0, 32'h00000FF0, 32'h3C00,     1'b0};
    vecs[5]  = '{4'b0110, 32'h0,        32'h0,        32'h0, 32'h0,   2'b00, 1'b0, 32'hFFFFFFFF, 32'h0,        1'b0};
    vecs[6]  = '{4'b0111, 32'hAAAA5555, 32'h0000FFFF, 32'h0, 32'h0,   2'b00, 1'b0, 32'hAAAAAAAA, 32'h3FFFC,    1'b0};
    vecs[7]  = '{4'b1000, 32'h1,        32'd31,       32'h0, 32'h0,   2'b00, 1'b0, 32'h80000000, 32'h7C,       1'b0};
    vecs[8]  = '{4'b1010, 32'h80000000, 32'h4,        32'h0, 32'h0,   2'b00, 1'b0, 32'h08000000, 32'h10,       1'b0};
    vecs[9]  = '{4'b0011, 32'h5,        32'h1,        32'h0, 32'h0,   2'b00, 1'b0, 32'h0,        32'h4,        1'b0};
    vecs[10] = '{4'b0000, 32'h3,        32'hFFFFFFFE, 32'h4, 32'h100, 2'b10, 1'b0, 32'h1,        32'hF8,       1'b1};
    vecs[11] = '{4'b0000, 32'h1,        32'h0,        32'h0, 32'h200, 2'b01, 1'b0, 32'h1,        32'h200,      1'b0};
    vecs[12] = '{4'b0000, 32'h0,        32'h1,        32'h0, 32'h40,  2'b01, 1'b0, 32'h1,        32'h44,       1'b1};
    vecs[13] = '{4'b0000, 32'h0,        32'h0,        32'h0, 32'h80,  2'b11, 1'b1, 32'h0,        32'h80,       1'b0};
    vecs[14] = '{4'b0000, 32'h0,        32'h0,        32'h0, 32'h80,  2'b11, 1'b0, 32'h0,        32'h80,       1'b1};
    vecs[15] = '{4'b0000, 32'h9,        32'h0,        32'h9, 32'h0,   2'b10, 1'b0, 32'h9,        32'h0,        1'b0};

    rst = 1'b1;
    applyStimulus(4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_stall", {31'b0, stall}, 32'd0);
    checkOutput("reset_md_done", {31'b0, md_done}, 32'd0);
    checkOutput("reset_result", alu_result, 32'h0);
    checkOutput("reset_br_addr", br_addr, 32'h0);
    checkOutput("reset_br_taken", {31'b0, br_taken}, 32'd0);
    nextCycle();
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].cmd, vecs[i].v1, vecs[i].v2, vecs[i].r2, vecs[i].pc, vecs[i].br, vecs[i].fl);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_result", i), alu_result, vecs[i].e_res);
      checkOutput($sformatf("vec%0d_br_addr", i), br_addr, vecs[i].e_addr);
      checkOutput($sformatf("vec%0d_br_taken", i), {31'b0, br_taken}, {31'b0, vecs[i].e_taken});
      checkOutput($sformatf("vec%0d_stall", i), {31'b0, stall}, 32'd0);
      nextCycle();
    end

    runMd(4'b1100, 32'd12345, 32'd6789, 32'd83810205, "mul_12345x6789");
    runMd(4'b1100, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, "mul_ffffffffx2");
    applyStimulus(4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0);
    @(negedge clk);
    checkOutput("after_done_md_done", {31'b0, md_done}, 32'd0);
    checkOutput("after_done_stall", {31'b0, stall}, 32'd0);
    nextCycle();

`ifdef EXE_DIV_EN
    runMd(4'b1101, 32'd100, 32'd7, 32'd14, "div_100_7");
    runMd(4'b1101, 32'd5, 32'd0, 32'hFFFFFFFF, "div_5_0");
`else
    applyStimulus(4'b1101, 32'd100, 32'd7, 32'h0, 32'h0, 2'b00, 1'b0);
    @(negedge clk);
    checkOutput("nodiv_result", alu_result, 32'h0);
    checkOutput("nodiv_stall", {31'b0, stall}, 32'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("nodiv_stall_next", {31'b0, stall}, 32'd0);
    checkOutput("nodiv_md_done_next", {31'b0, md_done}, 32'd0);
    nextCycle();
`endif

    applyStimulus(4'b1100, 32'd7, 32'd9, 32'h0, 32'h0, 2'b00, 1'b1);
    @(negedge clk);
    checkOutput("idle_flush_stall", {31'b0, stall}, 32'd0);
    nextCycle();
    applyStimulus(4'b0000, 32'd2, 32'd3, 32'h0, 32'h0, 2'b00, 1'b0);
    @(negedge clk);
    checkOutput("idle_flush_next_stall", {31'b0, stall}, 32'd0);
    checkOutput("idle_flush_next_result", alu_result, 32'd5);
    nextCycle();

    applyStimulus(4'b1100, 32'd7, 32'd9, 32'h0, 32'h0, 2'b00, 1'b0);
    nextCycle();
    repeat (5) nextCycle();
    flush = 1'b1;
    @(negedge clk);
    checkOutput("busy_flush_stall", {31'b0, stall}, 32'd0);
    checkOutput("busy_flush_md_done", {31'b0, md_done}, 32'd0);
    nextCycle();
    applyStimulus(4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0);
    pulsed = 0;
    stalled = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (md_done) pulsed = 1;
      if (stall) stalled = 1;
      nextCycle();
    end
    checkOutput("busy_flush_no_pulse", {31'b0, pulsed}, 32'd0);
    checkOutput("busy_flush_no_stall", {31'b0, stalled}, 32'd0);
    runMd(4'b1100, 32'd3, 32'd3, 32'd9, "mul_3x3");

    applyStimulus(4'b1100, 32'd5, 32'd6, 32'h0, 32'h0, 2'b00, 1'b0);
    nextCycle();
    repeat (10) nextCycle();
    @(negedge clk);
    checkOutput("busy10_stall", {31'b0, stall}, 32'd1);
    #1 rst = 1'b1;
    #1;
    checkOutput("rst_busy_stall", {31'b0, stall}, 32'd0);
    checkOutput("rst_busy_md_done", {31'b0, md_done}, 32'd0);
    nextCycle();
    applyStimulus(4'b0000, 32'd1, 32'd1, 32'h0, 32'h0, 2'b00, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_add", alu_result, 32'd2);
    checkOutput("post_rst_stall", {31'b0, stall}, 32'd0);
    checkOutput("post_rst_md_done", {31'b0, md_done}, 32'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("post_rst_idle_stall", {31'b0, stall}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
